// File: rtl/uart_tx_pkg.sv
// Shared UART transmit types: frame state encoding, parity sense and idle line level.
// The STOP2 encoding is only reachable when UART_TX_TWO_STOP_EN is defined.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5
    } state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: even sense gives the XOR of the bus, odd sense its inverse.
// Shared between the TX frame controller and the RX parity checker.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART TX frame controller: start, serializer data, optional parity, stop; Moore outputs, one bit per CLK.
// Define UART_TX_TWO_STOP_EN to append a second stop bit to every frame.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] bit_cnt;
    logic          par_bit;
    logic          par_q;
    logic          par_en_q;

    parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_calc (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_bit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Frame options are frozen at acceptance so upstream may move on mid-frame
            if (state == IDLE && Data_Valid) begin
                par_q    <= par_bit;
                par_en_q <= PAR_EN;
            end
            if (state == START) begin
                bit_cnt <= '0;
            end else if (state == DATA) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        TX_OUT    = IDLE_LINE;
        Busy      = 1'b0;
        ser_en    = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = Data_Valid ? START : IDLE;
            end
            START: begin
                TX_OUT    = 1'b0;
                Busy      = 1'b1;
                state_nxt = DATA;
            end
            DATA: begin
                TX_OUT = ser_data;
                Busy   = 1'b1;
                ser_en = 1'b1;
                // Bit count bounds the data phase even if the serializer never flags done
                if (ser_done || bit_cnt == LAST_BIT) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end else begin
                    state_nxt = DATA;
                end
            end
            PARITY: begin
                TX_OUT    = par_q;
                Busy      = 1'b1;
                state_nxt = STOP;
            end
            STOP: begin
                Busy = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                state_nxt = STOP2;
`else
                state_nxt = IDLE;
`endif
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
                Busy      = 1'b1;
                state_nxt = IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: a frame-list model predicts every output cycle, plus literal frame checks.
// The bench also plays the serializer, presenting each data bit LSB first while ser_en is expected.
module tb_uart_tx_fsm;
    import uart_tx_pkg::*;

    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int TWO = 1;
`else
    localparam int TWO = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data;
    logic          ser_en, TX_OUT, Busy;

    uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic tx;
        logic busy;
        logic en;
        bit   is_data;
        int   idx;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   exit_data;
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_on = 0;
    bit   stuck = 0;
    bit   stray = 0;
    int   early_at = DW - 1;
    bit   cap = 0;
    logic log_tx[$];
    int   busy_cnt, en_cnt;

    function automatic exp_t mk(logic tx, logic b, logic e, bit d, int i);
        exp_t r;
        r.tx = tx; r.busy = b; r.en = e; r.is_data = d; r.idx = i;
        return r;
    endfunction

    // Model: a queued list of per-cycle outputs for the frame in flight; empty list means idle line
    always @(posedge CLK) begin
        if (RST) begin
            q = {};
        end else if (q.size() > 0) begin
            exit_data = cur.is_data && (ser_done || cur.idx == DW - 1);
            void'(q.pop_front());
            if (exit_data)
                while (q.size() > 0 && q[0].is_data) void'(q.pop_front());
        end else if (Data_Valid) begin
            q.push_back(mk(1'b0, 1'b1, 1'b0, 0, 0));
            for (int i = 0; i < DW; i++) q.push_back(mk(P_DATA[i], 1'b1, 1'b1, 1, i));
            if (PAR_EN) begin
                // parity bit makes the total count of ones even (PAR_TYP=0) or odd (PAR_TYP=1)
                q.push_back(mk(logic'(($countones(P_DATA) + int'(PAR_TYP)) % 2), 1'b1, 1'b0, 0, 0));
            end
            q.push_back(mk(1'b1, 1'b1, 1'b0, 0, 0));
            if (TWO == 1) q.push_back(mk(1'b1, 1'b1, 1'b0, 0, 0));
        end
        cur = (q.size() > 0) ? q[0] : mk(1'b1, 1'b0, 1'b0, 0, 0);
    end

    // Serializer stand-in
    always @(posedge CLK) begin
        #1;
        if (cur.is_data) begin
            ser_data = cur.tx;
            ser_done = !stuck && (cur.idx == early_at);
        end else begin
            ser_data = 1'b0;
            ser_done = stray;
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            n_vec++;
            if ({TX_OUT, Busy, ser_en} !== {cur.tx, cur.busy, cur.en}) begin
                n_err++;
                $display("FAIL cycle t=%0t: tx/busy/en got %b%b%b want %b%b%b",
                         $time, TX_OUT, Busy, ser_en, cur.tx, cur.busy, cur.en);
            end
            if (cap && Busy === 1'b1) begin
                log_tx.push_back(TX_OUT);
                busy_cnt++;
                if (ser_en === 1'b1) en_cnt++;
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cap_start();
        log_tx = {};
        busy_cnt = 0;
        en_cnt = 0;
        cap = 1;
    endtask

    function automatic int log_seq();
        int s = 0;
        foreach (log_tx[i]) s = (s << 1) | int'(log_tx[i]);
        return s;
    endfunction

    task automatic send(input logic [DW-1:0] b, input logic pen, input logic ptyp);
        P_DATA = b; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (Busy !== 1'b0 && t < 60) begin
            @(negedge CLK);
            t++;
        end
        n_vec++;
        if (Busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s timeout: Busy got %b want 0", name, Busy);
        end
        cap = 0;
    endtask

    int idle_ok;
    int bseq, bexp;
    localparam int FL = DW + 3 + TWO;

    initial begin
        RST = 1'b1; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        ser_done = 1'b0; ser_data = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        chk_on = 1;

        // Reset then idle
        idle_ok = 0;
        repeat (20) begin
            if (TX_OUT === 1'b1 && Busy === 1'b0 && ser_en === 1'b0) idle_ok++;
            @(negedge CLK);
        end
        check_lit("idle_after_reset", idle_ok, 20);

        // Even parity frame
        cap_start();
        send(8'b1110_1101, 1'b1, PAR_EVEN);
        wait_idle("even");
        check_lit("even_seq", log_seq(), (TWO == 1) ? 12'b0101_1011_1011 : 11'b010_1101_1101);
        check_lit("even_busy", busy_cnt, 11 + TWO);
        check_lit("even_en", en_cnt, 8);

        // Odd parity, same byte
        cap_start();
        send(8'b1110_1101, 1'b1, PAR_ODD);
        wait_idle("odd");
        check_lit("odd_parity_bit", int'(log_tx[9]), 1);

        // No parity
        cap_start();
        send(8'b1110_1101, 1'b0, PAR_EVEN);
        wait_idle("nopar");
        check_lit("nopar_busy", busy_cnt, 10 + TWO);
        check_lit("nopar_stop_after_data", int'(log_tx[9]), 1);

        // Data_Valid held through the frame; PAR_TYP flips mid-frame
        cap_start();
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = PAR_EVEN; Data_Valid = 1'b1;
        bseq = 0; bexp = 0;
        for (int i = 0; i <= FL + 2; i++) begin
            bseq = (bseq << 1) | int'(Busy);
            bexp = (bexp << 1) | int'((i >= 1 && i <= FL) || i == FL + 2);
            if (i == 3) PAR_TYP = PAR_ODD;
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
        wait_idle("hold");
        check_lit("hold_busy_pattern", bseq, bexp);
        check_lit("hold_parity_unchanged", int'(log_tx[9]), 0);

        // Stuck serializer plus stray ser_done outside DATA
        stuck = 1; stray = 1;
        cap_start();
        send(8'h3C, 1'b1, PAR_EVEN);
        wait_idle("watchdog");
        check_lit("watchdog_en", en_cnt, 8);
        check_lit("watchdog_busy", busy_cnt, 11 + TWO);
        stuck = 0; stray = 0;

        // Early ser_done cuts the data phase short
        early_at = 3;
        cap_start();
        send(8'h5A, 1'b0, PAR_EVEN);
        wait_idle("early");
        check_lit("early_en", en_cnt, 4);
        early_at = DW - 1;

        // Reset during data bit 4
        send(8'b1110_1101, 1'b1, PAR_EVEN);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_lit("abort_tx", int'(TX_OUT), 1);
        check_lit("abort_busy", int'(Busy), 0);
        check_lit("abort_en", int'(ser_en), 0);
        cap_start();
        send(8'b1110_1101, 1'b1, PAR_EVEN);
        wait_idle("after_abort");
        check_lit("after_abort_seq", log_seq(), (TWO == 1) ? 12'b0101_1011_1011 : 11'b010_1101_1101);

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
Frame controller for the UART transmit path. It sits directly downstream of the serializer: it drives ser_en, consumes ser_done and ser_data, and muxes start, data, parity and stop bits onto the serial line TX_OUT. Parity is computed internally from the accepted byte. Busy tells the upstream source when a new byte may be offered.

Parameters:
DATA_WIDTH, 8, width of P_DATA and number of data bits per frame.

Ports:
CLK  input  1  system clock; one UART bit per CLK cycle (baud strobe is handled outside this block).
RST  input  1  synchronous, active-high reset.
P_DATA  input  DATA_WIDTH  parallel byte; the same bus feeds the serializer. Latched here for parity only.
Data_Valid  input  1  byte-offer strobe; accepted only in IDLE.
PAR_EN  input  1  1 = parity bit inserted; sampled at acceptance.
PAR_TYP  input  1  0 = even, 1 = odd; sampled at acceptance.
ser_done  input  1  serializer flag; high during the cycle it presents the last data bit.
ser_data  input  1  serializer bit output, LSB first.
ser_en  output  1  serializer shift enable.
TX_OUT  output  1  serial line; idles high.
Busy  output  1  frame in progress.

Behaviour:
- Reset (sync, RST=1 at rising CLK edge):
  - state=IDLE, bit counter=0, parity register=0.
  - TX_OUT=1, Busy=0, ser_en=0.
  - Reset mid-frame aborts the frame. The line returns high on the next cycle and no partial stop bit is sent.
- Outputs are Moore-decoded from the registered state. TX_OUT is a mux of (state, ser_data, parity register).
- States, transitions and outputs:
  - IDLE: TX_OUT=1, Busy=0, ser_en=0.
    - Data_Valid=1 → latch parity bit and PAR_EN/PAR_TYP, go to START.
    - Parity bit = ^P_DATA for even, ~^P_DATA for odd.
  - START: TX_OUT=0, Busy=1, ser_en=0. Unconditional → DATA; bit counter cleared.
  - DATA: TX_OUT=ser_data, Busy=1, ser_en=1. Bit counter increments each cycle.
    - Exit when ser_done=1 OR counter==DATA_WIDTH-1 (watchdog against a stuck serializer).
    - Exit goes to PARITY if the latched PAR_EN=1, else STOP.
  - PARITY: TX_OUT=latched parity bit, Busy=1, ser_en=0. → STOP.
  - STOP: TX_OUT=1, Busy=1, ser_en=0. → IDLE.
- Latency: Data_Valid in cycle 0 → start bit in cycle 1 → data bits in cycles 1+1..1+DATA_WIDTH.
- Frame length: 1+DATA_WIDTH+PAR_EN+1 cycles. Busy is high for exactly that many cycles.
- Data_Valid while Busy=1 is ignored, with no queuing. This includes Data_Valid during STOP: at least one IDLE cycle separates frames.
- P_DATA, PAR_EN and PAR_TYP changing mid-frame have no effect on the current frame.
- ser_done outside DATA is ignored.
- Illegal state encoding → IDLE on next edge.

Optional Feature:
UART_TX_TWO_STOP_EN.
- Defined: adds state STOP2 (TX_OUT=1, Busy=1). STOP → STOP2 → IDLE; frame is one cycle longer.
- Undefined: STOP2 does not exist; STOP → IDLE.
- State encoding width is unchanged either way (3 bits).

Decomposition:
- Package uart_tx_pkg:
  - state enum/localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, STOP2=5.
  - PAR_EVEN=0, PAR_ODD=1.
  - idle-line level constant (1).
- One sub-module: parity_calc.
  - Combinational inputs: DATA_WIDTH data bus, PAR_TYP.
  - Output: parity bit.
  - Reused later by the RX parity checker.

Test Plan:
1. Reset then idle: RST=1 for 1 cycle, then RST=0 with no Data_Valid → TX_OUT=1, Busy=0, ser_en=0 held for 20 cycles.
2. Even-parity frame: P_DATA=8'b11101101, PAR_EN=1, PAR_TYP=0, 1-cycle Data_Valid → TX_OUT sequence 0,1,0,1,1,0,1,1,1,0(parity),1(stop); Busy high 11 cycles; ser_en high exactly 8 cycles.
3. Odd parity, then no parity, same byte:
   - PAR_TYP=1 → parity bit = 1.
   - PAR_EN=0 → frame is 10 cycles, going straight from the last data bit to stop.
4. Busy rejection: Data_Valid held high through the whole frame with P_DATA=8'hA5 → exactly one frame sent, then the next frame starts only after one IDLE cycle. Changing PAR_TYP mid-frame does not alter the parity bit.
5. Watchdog and stray ser_done:
   - ser_done tied 0 → DATA exits after 8 cycles anyway.
   - ser_done pulsed during START/PARITY → ignored.
6. Reset mid-frame: RST=1 during data bit 4 → next cycle TX_OUT=1, Busy=0, ser_en=0. A following Data_Valid produces a clean full frame. With UART_TX_TWO_STOP_EN defined, scenario 2 shows two stop cycles (Busy 12 cycles).
